// File: rtl/m68k_bus_responder_if.sv
// Signal bundle between the 68000 bus pins / local backend port and m68k_bus_responder.
interface m68k_bus_responder_if;
   logic        m68k_clk;
   logic        m68k_as_n;
   logic        m68k_uds_n;
   logic        m68k_lds_n;
   logic        m68k_rw;
   logic [2:0]  m68k_fc;
   logic [23:1] m68k_a;
   logic [15:0] m68k_d_in;
   logic [15:0] m68k_d_out;
   logic        m68k_d_oe;
   logic        m68k_dtack_drv;
   logic        m68k_berr_drv;
   logic        lcl_req;
   logic        lcl_we;
   logic [23:0] lcl_addr;
   logic [1:0]  lcl_be;
   logic [15:0] lcl_wdata;
   logic [15:0] lcl_rdata;
   logic        lcl_ack;
   logic        lcl_err;

   modport slave (
      input  m68k_clk, m68k_as_n, m68k_uds_n, m68k_lds_n, m68k_rw, m68k_fc, m68k_a,
             m68k_d_in, lcl_rdata, lcl_ack, lcl_err,
      output m68k_d_out, m68k_d_oe, m68k_dtack_drv, m68k_berr_drv,
             lcl_req, lcl_we, lcl_addr, lcl_be, lcl_wdata
   );

   modport master (
      output m68k_clk, m68k_as_n, m68k_uds_n, m68k_lds_n, m68k_rw, m68k_fc, m68k_a,
             m68k_d_in, lcl_rdata, lcl_ack, lcl_err,
      input  m68k_d_out, m68k_d_oe, m68k_dtack_drv, m68k_berr_drv,
             lcl_req, lcl_we, lcl_addr, lcl_be, lcl_wdata
   );
endinterface

// File: rtl/m68k_bus_responder.sv
// 68000 bus target: claims cycles inside an address window, forwards them to a
// single-beat local req/ack port and terminates them with DTACK or BERR.
module m68k_bus_responder #(
   parameter logic [23:0] BASE_ADDR   = 24'hE80000,
   parameter logic [23:0] WIN_MASK    = 24'hFF0000,
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned TIMEOUT     = 64
) (
   input logic                 pi_clk,
   input logic                 rst,
   m68k_bus_responder_if.slave bus
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_ARMWAIT, S_IDLE, S_ACCESS, S_WAIT, S_TERM} state_t;

   logic [2:0]    clk_sync;
   logic [1:0]    as_sync, uds_sync, lds_sync;
   logic          clk_fall, clk_rise, as_n_s, strobe, hit;

   state_t        state, state_d;
   logic          req, req_d, we, we_d, d_oe, d_oe_d, dtack, dtack_d, berr, berr_d;
   logic          wdata_done, wdata_done_d;
   logic [23:0]   addr, addr_d;
   logic [1:0]    be, be_d;
   logic [15:0]   wdata, wdata_d, d_out, d_out_d;
   logic [3:0]    wait_cnt, wait_d;
   logic [TW-1:0] to_cnt, to_d;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge pi_clk) begin
      if (rst) begin
         clk_sync <= '0;
         // Strobes reset to the asserted level so ARMWAIT exits only on a real AS_n high.
         as_sync  <= '0;
         uds_sync <= '0;
         lds_sync <= '0;
      end else begin
         clk_sync <= {clk_sync[1:0], bus.m68k_clk};
         as_sync  <= {as_sync[0], bus.m68k_as_n};
         uds_sync <= {uds_sync[0], bus.m68k_uds_n};
         lds_sync <= {lds_sync[0], bus.m68k_lds_n};
      end
   end

   assign clk_fall = clk_sync[2] & ~clk_sync[1];
   assign clk_rise = ~clk_sync[2] & clk_sync[1];
   assign as_n_s   = as_sync[1];
   assign strobe   = ~uds_sync[1] | ~lds_sync[1];
   assign hit      = ((({bus.m68k_a, 1'b0}) ^ BASE_ADDR) & WIN_MASK) == 24'h0;

   always_ff @(posedge pi_clk) begin
      if (rst) begin
         state      <= S_ARMWAIT;
         req        <= 1'b0;
         we         <= 1'b0;
         addr       <= '0;
         be         <= '0;
         wdata      <= '0;
         wdata_done <= 1'b0;
         d_out      <= '0;
         d_oe       <= 1'b0;
         dtack      <= 1'b0;
         berr       <= 1'b0;
         wait_cnt   <= '0;
         to_cnt     <= '0;
      end else begin
         state      <= state_d;
         req        <= req_d;
         we         <= we_d;
         addr       <= addr_d;
         be         <= be_d;
         wdata      <= wdata_d;
         wdata_done <= wdata_done_d;
         d_out      <= d_out_d;
         d_oe       <= d_oe_d;
         dtack      <= dtack_d;
         berr       <= berr_d;
         wait_cnt   <= wait_d;
         to_cnt     <= to_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets its hold value first so no path can infer a latch.
      state_d      = state;
      req_d        = req;
      we_d         = we;
      addr_d       = addr;
      be_d         = be;
      wdata_d      = wdata;
      wdata_done_d = wdata_done;
      d_out_d      = d_out;
      d_oe_d       = d_oe;
      dtack_d      = dtack;
      berr_d       = berr;
      wait_d       = wait_cnt;
      to_d         = to_cnt;

      unique case (state)
         S_ARMWAIT: if (as_n_s) state_d = S_IDLE;
         S_IDLE: begin
            if (clk_fall && !as_n_s && strobe && bus.m68k_fc != 3'b111 && hit) begin
               we_d         = ~bus.m68k_rw;
               addr_d       = {bus.m68k_a, 1'b0};
               be_d         = {~uds_sync[1], ~lds_sync[1]};
               req_d        = 1'b1;
               wait_d       = 4'(WAIT_STATES);
               to_d         = '0;
               wdata_done_d = 1'b0;
               state_d      = S_ACCESS;
            end
         end
         S_ACCESS: begin
            // The 68000 presents write data a phase after AS, so capture it once on a strobed fall.
            if (we && !wdata_done && clk_fall && strobe) begin
               wdata_d      = bus.m68k_d_in;
               wdata_done_d = 1'b1;
            end
            if (as_n_s) begin
               req_d   = 1'b0;
               d_oe_d  = 1'b0;
               state_d = S_IDLE;
            end else if (bus.lcl_ack) begin
               req_d = 1'b0;
               if (!we) begin
                  d_out_d = bus.lcl_rdata;
                  d_oe_d  = 1'b1;
               end
               if (bus.lcl_err) begin
                  berr_d  = 1'b1;
                  state_d = S_TERM;
               end else begin
                  state_d = S_WAIT;
               end
            end else if (clk_fall) begin
               if (to_cnt == TW'(TIMEOUT - 1)) begin
                  to_d    = TW'(TIMEOUT);
                  req_d   = 1'b0;
                  berr_d  = 1'b1;
                  state_d = S_TERM;
               end else begin
                  to_d = to_cnt + 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (as_n_s) begin
               d_oe_d  = 1'b0;
               state_d = S_IDLE;
            end else if (wait_cnt == 4'd0) begin
               if (clk_rise) begin
                  dtack_d = 1'b1;
                  state_d = S_TERM;
               end
            end else if (clk_fall) begin
               wait_d = wait_cnt - 1'b1;
            end
         end
         S_TERM: begin
            if (as_n_s) begin
               dtack_d = 1'b0;
               berr_d  = 1'b0;
               d_oe_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_ARMWAIT;
      endcase
   end

   assign bus.m68k_d_out     = d_out;
   assign bus.m68k_d_oe      = d_oe;
   assign bus.m68k_dtack_drv = dtack;
   assign bus.m68k_berr_drv  = berr;
   assign bus.lcl_req        = req;
   assign bus.lcl_we         = we;
   assign bus.lcl_addr       = addr;
   assign bus.lcl_be         = be;
   assign bus.lcl_wdata      = wdata;

endmodule
